// File: rtl/rr_arbiter4.sv
// Four-client round-robin arbiter driving a one-hot decoded grant with enable.
// Define RR_ARBITER4_TIMEOUT_EN to build in the MAX_HOLD forced-release counter.
module rr_arbiter4 #(
    parameter int MAX_HOLD = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    input  logic       done,
    output logic [3:0] gnt,
    output logic [1:0] gnt_idx,
    output logic       gnt_valid,
    output logic       timeout
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t     state_q, state_d;
    logic [1:0] ptr_q, ptr_d;
    logic [1:0] gnt_idx_q, gnt_idx_d;
    logic       timeout_q, timeout_d;
    logic [1:0] pick;
    logic [1:0] cand;
    logic       found;
    logic       normal_release;
    logic       force_release;

`ifdef RR_ARBITER4_TIMEOUT_EN
    localparam logic [7:0] HoldLast = 8'(MAX_HOLD - 1);

    logic [7:0] hold_q, hold_d;

    assign force_release = (hold_q == HoldLast);

    always_comb begin
        hold_d = hold_q;
        if (state_q == IDLE) begin
            hold_d = 8'd0;
        end else if (!normal_release && !force_release) begin
            hold_d = hold_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_q <= 8'd0;
        end else begin
            hold_q <= hold_d;
        end
    end
`else
    // Without the counter a grant never times out; the compare only keeps MAX_HOLD referenced.
    assign force_release = (MAX_HOLD < 0);
`endif

    // First requester at or after ptr, scanning upward with wrap.
    always_comb begin
        pick  = ptr_q;
        cand  = ptr_q;
        found = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cand = ptr_q + 2'(i);
            if (!found && req[cand]) begin
                pick  = cand;
                found = 1'b1;
            end
        end
    end

    assign normal_release = done || !req[gnt_idx_q];

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        gnt_idx_d = gnt_idx_q;
        timeout_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (found) begin
                    gnt_idx_d = pick;
                    state_d   = GRANT;
                end
            end
            GRANT: begin
                if (normal_release || force_release) begin
                    state_d   = IDLE;
                    ptr_d     = gnt_idx_q + 2'd1;
                    timeout_d = !normal_release;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            ptr_q     <= 2'd0;
            gnt_idx_q <= 2'd0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            gnt_idx_q <= gnt_idx_d;
            timeout_q <= timeout_d;
        end
    end

    assign gnt_valid = (state_q == GRANT);
    assign gnt_idx   = gnt_idx_q;
    assign gnt       = gnt_valid ? (4'b0001 << gnt_idx_q) : 4'b0000;
    assign timeout   = timeout_q;

endmodule

// File: tb/tb_rr_arbiter4.sv
// Randomised and directed bench for rr_arbiter4 against a cycle-level behavioural model.
// Follows RR_ARBITER4_TIMEOUT_EN the same way the design does.
module tb_rr_arbiter4;

    localparam int MaxHold = 4;
`ifdef RR_ARBITER4_TIMEOUT_EN
    localparam bit TimeoutEn = 1'b1;
`else
    localparam bit TimeoutEn = 1'b0;
`endif

    logic       clk;
    logic       rst_n;
    logic [3:0] req;
    logic       done;
    logic [3:0] gnt;
    logic [1:0] gnt_idx;
    logic       gnt_valid;
    logic       timeout;

    int testCount;
    int failCount;

    // Model state: who owns the resource, how long it has held it, and where the scan starts.
    bit m_busy;
    int m_owner;
    int m_ptr;
    int m_cycles;
    bit m_timeout;

    rr_arbiter4 #(.MAX_HOLD(MaxHold)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .done      (done),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid),
        .timeout   (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        testCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s at %0t: got %0h, expected %0h", tag, $time, actual, expected);
        end
    endtask

    task automatic resetModel();
        m_busy    = 1'b0;
        m_owner   = 0;
        m_ptr     = 0;
        m_cycles  = 0;
        m_timeout = 1'b0;
    endtask

    // Advance the model by one clock edge using the inputs the DUT is about to sample.
    task automatic modelEdge();
        bit withdrew;
        bit forced;
        m_timeout = 1'b0;
        if (!m_busy) begin
            for (int k = 0; k < 4; k++) begin
                if (!m_busy && req[(m_ptr + k) % 4]) begin
                    m_owner  = (m_ptr + k) % 4;
                    m_busy   = 1'b1;
                    m_cycles = 1;
                end
            end
        end else begin
            withdrew = (req[m_owner] == 1'b0);
            forced   = TimeoutEn && (m_cycles == MaxHold);
            if (done || withdrew || forced) begin
                m_busy    = 1'b0;
                m_ptr     = (m_owner + 1) % 4;
                m_timeout = !(done || withdrew);
            end else begin
                m_cycles++;
            end
        end
    endtask

    task automatic checkAll(input string tag);
        logic [3:0] expGnt;
        expGnt = m_busy ? (4'b0001 << m_owner) : 4'b0000;
        checkOutput({tag, ".gnt"}, 32'(gnt), 32'(expGnt));
        checkOutput({tag, ".gnt_idx"}, 32'(gnt_idx), 32'(m_owner));
        checkOutput({tag, ".gnt_valid"}, 32'(gnt_valid), 32'(m_busy));
        checkOutput({tag, ".timeout"}, 32'(timeout), 32'(m_timeout));
    endtask

    task automatic applyStimulus(input logic [3:0] r, input logic d, input string tag);
        req  = r;
        done = d;
        modelEdge();
        @(posedge clk);
        #1;
        checkAll(tag);
    endtask

    initial begin
        testCount = 0;
        failCount = 0;
        req   = 4'b0000;
        done  = 1'b0;
        rst_n = 1'b0;
        resetModel();
        #12;
        checkAll("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checkAll("after_reset");

        // Single request from client 2, then release by done.
        applyStimulus(4'b0100, 1'b0, "single_grant");
        checkOutput("single_gnt_literal", 32'(gnt), 32'h4);
        applyStimulus(4'b0100, 1'b1, "single_done");
        applyStimulus(4'b0000, 1'b0, "idle_empty");
        applyStimulus(4'b0000, 1'b1, "idle_done_ignored");

        // All clients requesting with done on every grant cycle: pointer starts at 3.
        for (int i = 0; i < 12; i++) begin
            applyStimulus(4'b1111, m_busy, "round_robin");
        end
        applyStimulus(4'b0000, 1'b0, "rr_drain");
        applyStimulus(4'b0000, 1'b0, "rr_drain2");

        // Steer the pointer to 1, then client 1 withdraws while 0 and 3 wait.
        while (m_ptr != 1) begin
            applyStimulus(4'b1111, m_busy, "steer_ptr");
        end
        applyStimulus(4'b0000, 1'b0, "steer_idle");
        applyStimulus(4'b0010, 1'b0, "withdraw_grant");
        applyStimulus(4'b1001, 1'b0, "withdraw_release");
        applyStimulus(4'b1001, 1'b0, "withdraw_next");
        checkOutput("withdraw_owner3", 32'(gnt_idx), 32'd3);
        applyStimulus(4'b0000, 1'b0, "withdraw_drop");

        // Long hold with no done: times out with the counter built in, persists otherwise.
        for (int i = 0; i < 100; i++) begin
            applyStimulus(4'b0001, 1'b0, "long_hold");
        end
        applyStimulus(4'b0000, 1'b0, "long_hold_end");
        applyStimulus(4'b0000, 1'b0, "long_hold_idle");

        // Asynchronous reset in the middle of a grant to client 3.
        applyStimulus(4'b1000, 1'b0, "pre_async");
        applyStimulus(4'b1000, 1'b0, "pre_async2");
        #3;
        rst_n = 1'b0;
        resetModel();
        #1;
        checkAll("async_reset");
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(4'b1000, 1'b0, "regrant");
        applyStimulus(4'b0000, 1'b0, "regrant_drop");

        // Random traffic; done is occasionally driven while idle too.
        for (int i = 0; i < 400; i++) begin
            applyStimulus(4'($urandom_range(0, 15)), ($urandom_range(0, 3) == 0), "random");
        end

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
